// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the sequencer and its decoder.
package cpu_pkg;

    // Instruction field positions (16-bit word)
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LDI  = 4'h5,
        OP_MOV  = 4'h6,
        OP_BR   = 4'h8,
        OP_BZ   = 4'h9,
        OP_BN   = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_PASS = 3'd4
    } alu_func_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    // Coarse instruction class the sequencer dispatches on
    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LDI  = 3'd2,
        CLS_BR   = 3'd3,
        CLS_BZ   = 3'd4,
        CLS_BN   = 3'd5,
        CLS_HALT = 3'd6,
        CLS_ILL  = 3'd7
    } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Pure combinational instruction decoder: splits a 16-bit word into class,
// ALU function and raw register/immediate fields. No gating by state here.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output op_class_t   op_class,
    output alu_func_t   alu_func,
    output logic [2:0]  rd,
    output logic [2:0]  rs,
    output logic [7:0]  imm,
    output logic        illegal
);

    assign rd  = instr[RD_MSB:RD_LSB];
    assign rs  = instr[RS_MSB:RS_LSB];
    assign imm = instr[IMM_MSB:IMM_LSB];

    // Map opcode to class and ALU function; undefined opcodes fall to CLS_ILL
    always_comb begin
        op_class = CLS_ILL;
        alu_func = ALU_ADD;
        case (instr[OPC_MSB:OPC_LSB])
            OP_NOP:  op_class = CLS_NOP;
            OP_ADD:  begin op_class = CLS_ALU; alu_func = ALU_ADD;  end
            OP_SUB:  begin op_class = CLS_ALU; alu_func = ALU_SUB;  end
            OP_AND:  begin op_class = CLS_ALU; alu_func = ALU_AND;  end
            OP_OR:   begin op_class = CLS_ALU; alu_func = ALU_OR;   end
            OP_MOV:  begin op_class = CLS_ALU; alu_func = ALU_PASS; end
            OP_LDI:  op_class = CLS_LDI;
            OP_BR:   op_class = CLS_BR;
            OP_BZ:   op_class = CLS_BZ;
            OP_BN:   op_class = CLS_BN;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILL;
        endcase
    end

    assign illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute control FSM. Two cycles per instruction (FETCH, EXEC);
// controls are combinational from state + instr and live for the EXEC cycle
// only. State and Z/N flags are the only registered information.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int p_size = 6,
    parameter int i_size = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [i_size-1:0] instr,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              pc_incr,
    output logic              pc_relbranch,
    output logic [p_size-1:0] branch_addr,
    output logic [2:0]        alu_func,
    output logic              reg_we,
    output logic [2:0]        rd_addr,
    output logic [2:0]        rs_addr,
    output logic              imm_sel,
    output logic [7:0]        imm,
    output logic              halted,
    output logic              illegal
);

    seq_state_t state_q, state_d;
    logic       z_q, z_d;
    logic       n_q, n_d;

    op_class_t  dec_class;
    alu_func_t  dec_func;
    logic [2:0] dec_rd;
    logic [2:0] dec_rs;
    logic [7:0] dec_imm;
    logic       dec_ill;

    instr_decode u_decode (
        .instr    (instr),
        .op_class (dec_class),
        .alu_func (dec_func),
        .rd       (dec_rd),
        .rs       (dec_rs),
        .imm      (dec_imm),
        .illegal  (dec_ill)
    );

    // Next state, flag update and EXEC-cycle control decode
    always_comb begin
        state_d      = state_q;
        z_d          = z_q;
        n_d          = n_q;
        pc_incr      = 1'b0;
        pc_relbranch = 1'b0;
        branch_addr  = '0;
        alu_func     = 3'd0;
        reg_we       = 1'b0;
        rd_addr      = 3'd0;
        rs_addr      = 3'd0;
        imm_sel      = 1'b0;
        imm          = 8'd0;
        illegal      = 1'b0;

        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec_class)
                    CLS_NOP: pc_incr = 1'b1;
                    CLS_ALU: begin
                        reg_we   = 1'b1;
                        rd_addr  = dec_rd;
                        rs_addr  = dec_rs;
                        alu_func = dec_func;
                        pc_incr  = 1'b1;
                        z_d      = alu_z;
                        n_d      = alu_n;
                    end
                    CLS_LDI: begin
                        reg_we  = 1'b1;
                        imm_sel = 1'b1;
                        imm     = dec_imm;
                        rd_addr = dec_rd;
                        pc_incr = 1'b1;
                    end
                    CLS_BR: begin
                        pc_relbranch = 1'b1;
                        branch_addr  = instr[p_size-1:0];
                    end
                    // Conditional branches test the flags left by the last ALU op
                    CLS_BZ, CLS_BN: begin
                        if ((dec_class == CLS_BZ) ? z_q : n_q) begin
                            pc_relbranch = 1'b1;
                            branch_addr  = instr[p_size-1:0];
                        end else begin
                            pc_incr = 1'b1;
                        end
                    end
                    CLS_HALT: state_d = ST_HALTED;
                    CLS_ILL: begin
                        illegal = dec_ill;
                        pc_incr = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    assign halted = (state_q == ST_HALTED);

    // State and condition flags; async reset returns to FETCH with clear flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_FETCH;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (p_size=6). All outputs are packed into
// one vector and compared against hand-computed expectations.
module tb_cpu_sequencer;

    logic        clk;
    logic        n_reset;
    logic [15:0] instr;
    logic        alu_z;
    logic        alu_n;
    logic        pc_incr;
    logic        pc_relbranch;
    logic [5:0]  branch_addr;
    logic [2:0]  alu_func;
    logic        reg_we;
    logic [2:0]  rd_addr;
    logic [2:0]  rs_addr;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        halted;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer #(.p_size(6), .i_size(16)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .instr        (instr),
        .alu_z        (alu_z),
        .alu_n        (alu_n),
        .pc_incr      (pc_incr),
        .pc_relbranch (pc_relbranch),
        .branch_addr  (branch_addr),
        .alu_func     (alu_func),
        .reg_we       (reg_we),
        .rd_addr      (rd_addr),
        .rs_addr      (rs_addr),
        .imm_sel      (imm_sel),
        .imm          (imm),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {halted, illegal, pc_incr, pc_relbranch, branch_addr, alu_func, reg_we, rd, rs, imm_sel, imm}
    function automatic logic [28:0] mk(input logic h, input logic ill, input logic inc,
                                       input logic rel, input logic [5:0] br, input logic [2:0] fn,
                                       input logic we, input logic [2:0] rd, input logic [2:0] rs,
                                       input logic sel, input logic [7:0] im);
        return {h, ill, inc, rel, br, fn, we, rd, rs, sel, im};
    endfunction

    function automatic logic [28:0] outs();
        return {halted, illegal, pc_incr, pc_relbranch, branch_addr, alu_func,
                reg_we, rd_addr, rs_addr, imm_sel, imm};
    endfunction

    task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH, runs one instruction, returns in the next FETCH
    task automatic run(input string tag, input logic [15:0] i, input logic z, input logic n,
                       input logic [28:0] e);
        instr = i;
        alu_z = z;
        alu_n = n;
        #1;
        check({tag, "_fetch"}, outs(), '0);
        tick();
        check({tag, "_exec"}, outs(), e);
        tick();
    endtask

    initial begin
        n_reset = 1'b0;
        instr   = 16'h1280;
        alu_z   = 1'b0;
        alu_n   = 1'b0;

        repeat (2) tick();
        check("reset_hold", outs(), '0);

        // Release: first cycle is FETCH, then ADD repeats every two cycles
        n_reset = 1'b1;
        run("add1", 16'h1280, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,1,3'd1,3'd2,0,8'h00));
        run("add2", 16'h1280, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,1,3'd1,3'd2,0,8'h00));

        // Reset asserted mid-EXEC kills the pulse immediately and no flag load happens
        instr = 16'h1280;
        alu_z = 1'b1;
        alu_n = 1'b1;
        tick();
        n_reset = 1'b0;
        #1;
        check("reset_mid_exec", outs(), '0);
        tick();
        n_reset = 1'b1;
        run("bz_after_rst", 16'h90FD, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));
        run("bn_after_rst", 16'hA005, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));

        // SUB sets Z, BZ -3 taken
        run("sub_z1", 16'h2280, 1'b1, 1'b0, mk(0,0,1,0,6'd0,3'd1,1,3'd1,3'd2,0,8'h00));
        run("bz_taken", 16'h90FD, 1'b0, 1'b0, mk(0,0,0,1,6'b111101,3'd0,0,3'd0,3'd0,0,8'h00));

        // SUB clears Z; current-cycle alu_z must not influence BZ
        run("sub_z0", 16'h2280, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd1,1,3'd1,3'd2,0,8'h00));
        run("bz_not_taken", 16'h90FD, 1'b1, 1'b0, mk(0,0,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));

        // ADD sets N, BN +5 taken
        run("add_n1", 16'h1280, 1'b0, 1'b1, mk(0,0,1,0,6'd0,3'd0,1,3'd1,3'd2,0,8'h00));
        run("bn_taken", 16'hA005, 1'b0, 1'b0, mk(0,0,0,1,6'd5,3'd0,0,3'd0,3'd0,0,8'h00));

        // LDI does not disturb flags
        run("sub_z1b", 16'h2280, 1'b1, 1'b0, mk(0,0,1,0,6'd0,3'd1,1,3'd1,3'd2,0,8'h00));
        run("ldi", 16'h562A, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,1,3'd3,3'd0,1,8'h2A));
        run("bz_after_ldi", 16'h90FD, 1'b0, 1'b0, mk(0,0,0,1,6'b111101,3'd0,0,3'd0,3'd0,0,8'h00));

        // Illegal opcode pulses illegal, advances PC, keeps flags
        run("ill", 16'hC000, 1'b0, 1'b0, mk(0,1,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));
        run("bz_after_ill", 16'h90FD, 1'b0, 1'b0, mk(0,0,0,1,6'b111101,3'd0,0,3'd0,3'd0,0,8'h00));
        run("ill7", 16'h7E55, 1'b0, 1'b0, mk(0,1,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));

        // Remaining ALU functions; MOV also loads flags
        run("and", 16'h3A40, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd2,1,3'd5,3'd1,0,8'h00));
        run("or", 16'h4FC0, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd3,1,3'd7,3'd7,0,8'h00));
        run("mov_z1", 16'h6280, 1'b1, 1'b0, mk(0,0,1,0,6'd0,3'd4,1,3'd1,3'd2,0,8'h00));
        run("bz_after_mov", 16'h9001, 1'b0, 1'b0, mk(0,0,0,1,6'd1,3'd0,0,3'd0,3'd0,0,8'h00));

        // NOP and unconditional self-loop branch
        run("nop", 16'h0000, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));
        run("br_zero", 16'h8000, 1'b0, 1'b0, mk(0,0,0,1,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));
        run("br_trunc", 16'h80C7, 1'b0, 1'b0, mk(0,0,0,1,6'h07,3'd0,0,3'd0,3'd0,0,8'h00));

        // HALT: no PC movement in EXEC, then sticky halted with instr ignored
        instr = 16'hF000;
        #1;
        check("halt_fetch", outs(), '0);
        tick();
        check("halt_exec", outs(), '0);
        tick();
        instr = 16'h1280;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("halted_%0d", k), outs(), mk(1,0,0,0,6'd0,3'd0,0,3'd0,3'd0,0,8'h00));
            tick();
        end

        // Reset pulse clears halted and restarts at FETCH
        n_reset = 1'b0;
        #1;
        check("halt_reset", outs(), '0);
        tick();
        n_reset = 1'b1;
        run("add_after_halt", 16'h1280, 1'b0, 1'b0, mk(0,0,1,0,6'd0,3'd0,1,3'd1,3'd2,0,8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
